key_vault_reader: RTL
=====================

KEY_VAULT_READER -- requirements
Module: key_vault_reader

Interface
REQ-001 Parameter SLOTS, default 4: number of secret slots (power of two).
REQ-002 Parameter WIDTH, default 32: secret word width in bits.
REQ-003 clk  input  1  clock; all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 wr_en  input  1  writer strobe, one write per asserted cycle.
REQ-006 wr_slot  input  log2(SLOTS)  slot index for the write.
REQ-007 wr_data  input  WIDTH  secret word to store.
REQ-008 wr_err  output  1  one-cycle pulse when a write is rejected.
REQ-009 zeroize  input  1  global scrub request; clears all slots.
REQ-010 rd_req  input  1  read request, sampled only in IDLE.
REQ-011 rd_slot  input  log2(SLOTS)  slot index for the read.
REQ-012 rd_err  output  1  one-cycle pulse when a read targets an empty slot.
REQ-013 rd_busy  output  1  high whenever the FSM is not IDLE.
REQ-014 out_valid  output  1  secret word presented on out_data.
REQ-015 out_ready  input  1  consumer accepts out_data when high with out_valid.
REQ-016 out_data  output  WIDTH  secret word being delivered.
REQ-017 slot_full  output  SLOTS  bit i high when slot i holds an undelivered secret.

Function
REQ-018 Storage SHALL be SLOTS registers of WIDTH bits plus the slot_full flag vector.
REQ-019 A write SHALL be accepted only when the target slot is empty and is not the slot currently held by the read FSM; on acceptance, data is stored and slot_full is set on the next edge.
REQ-020 A write to a full slot or to the active read slot SHALL be dropped, leave the stored data unchanged, and pulse wr_err for one cycle in the following cycle.
REQ-021 FSM states SHALL be IDLE, FETCH, PRESENT and SCRUB.
REQ-022 IDLE: rd_req with slot_full[rd_slot]=1 -> FETCH, latching rd_slot; rd_req with an empty slot -> pulse rd_err for one cycle and stay IDLE.
REQ-023 FETCH: copy the slot word into the out_data register -> PRESENT; out_valid rises on entering PRESENT (rd_req at edge N gives out_valid=1 after edge N+2).
REQ-024 PRESENT: hold out_valid=1 and out_data stable until out_ready=1; on the handshake cycle -> SCRUB.
REQ-025 SCRUB (one cycle): the slot register SHALL be written to zero, its slot_full bit cleared, out_data zeroed and out_valid low -> IDLE.
REQ-026 out_data SHALL equal zero in every cycle in which out_valid=0; no stale secret may be visible.
REQ-027 A delivered secret SHALL NOT be readable again; a second read of the same slot yields rd_err until a new write occurs.
REQ-028 zeroize SHALL, on the next edge, clear all slot registers, slot_full, out_data and out_valid, and force the FSM to IDLE, aborting any read in progress.
REQ-029 Priority SHALL be rst > zeroize > scrub/read activity > write; a write coincident with zeroize is dropped without wr_err.
REQ-030 A write and a read of different slots in the same cycle SHALL both proceed independently.
REQ-031 rd_req asserted while rd_busy=1 SHALL be ignored with no rd_err.

Reset
REQ-032 On rst, all slot registers, slot_full, out_data, out_valid, wr_err and rd_err SHALL be zero and the FSM SHALL be IDLE.
REQ-033 rst asserted mid-read (FETCH/PRESENT/SCRUB) SHALL abort the read with all state zeroed; no word from the aborted read may be delivered afterwards.

Verification
REQ-034 Write slot 2 = 0xDEADBEEF, rd_req slot 2, out_ready=1 -> out_valid with 0xDEADBEEF two cycles after rd_req; next cycle slot_full[2]=0, out_data=0.
REQ-035 Read of empty slot 1 -> rd_err pulse for one cycle; rd_busy stays 0; out_valid stays 0.
REQ-036 Slot 0 = 0x12345678, rd_req, hold out_ready=0 for 5 cycles -> out_valid and out_data stable; write to slot 0 during this time -> wr_err, and the delivered word is still 0x12345678.
REQ-037 Slots 0-3 filled, zeroize asserted during PRESENT -> next cycle slot_full=0000, out_valid=0, out_data=0; a subsequent read of any slot gives rd_err.
REQ-038 Reset asserted during PRESENT on slot 3 = 0xA5A5A5A5 -> all outputs zero after the reset edge; after a new write of 0x1 and a read, 0x1 is delivered (never 0xA5A5A5A5).
REQ-039 Same-cycle write to slot 1 and read of slot 0 -> both succeed; a second read of slot 0 -> rd_err.

Source files
------------

// File: rtl/key_vault_if.sv
// Bundle of the writer, reader and delivery signals for key_vault_reader.
// The master modport is the system side and the slave modport is the vault side.
interface key_vault_if #(
   parameter int unsigned SLOTS = 4,
   parameter int unsigned WIDTH = 32
) ();
   localparam int unsigned IDX_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;

   logic             wr_en;
   logic [IDX_W-1:0] wr_slot;
   logic [WIDTH-1:0] wr_data;
   logic             wr_err;
   logic             zeroize;
   logic             rd_req;
   logic [IDX_W-1:0] rd_slot;
   logic             rd_err;
   logic             rd_busy;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic [SLOTS-1:0] slot_full;

   modport master (
      output wr_en, wr_slot, wr_data, zeroize, rd_req, rd_slot, out_ready,
      input  wr_err, rd_err, rd_busy, out_valid, out_data, slot_full
   );

   modport slave (
      input  wr_en, wr_slot, wr_data, zeroize, rd_req, rd_slot, out_ready,
      output wr_err, rd_err, rd_busy, out_valid, out_data, slot_full
   );
endinterface

// File: rtl/key_vault_reader.sv
// Write-once secret vault: each stored word is delivered once over a valid/ready port
// and then scrubbed, so a secret can never be read twice or linger on out_data.
module key_vault_reader #(
   parameter int unsigned SLOTS = 4,
   parameter int unsigned WIDTH = 32
) (
   input logic         clk,
   input logic         rst,
   key_vault_if.slave  bus
);
   localparam int unsigned IDX_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;

   typedef enum logic [1:0] {StIdle, StFetch, StPresent, StScrub} state_e;

   state_e           state_q;
   logic [IDX_W-1:0] rd_slot_q;
   logic [WIDTH-1:0] slots_q [SLOTS];
   logic [SLOTS-1:0] slot_full_q;
   logic [WIDTH-1:0] out_data_q;
   logic             out_valid_q;
   logic             wr_err_q;
   logic             rd_err_q;

   logic wr_hits_active;
   logic wr_accept;

   // The slot owned by an in-flight read is locked against writes until it returns to idle.
   assign wr_hits_active = (state_q != StIdle) && (bus.wr_slot == rd_slot_q);
   assign wr_accept      = bus.wr_en && !slot_full_q[bus.wr_slot] && !wr_hits_active;

   always_ff @(posedge clk) begin
      if (rst || bus.zeroize) begin
         state_q     <= StIdle;
         rd_slot_q   <= '0;
         slots_q     <= '{default: '0};
         slot_full_q <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         wr_err_q    <= 1'b0;
         rd_err_q    <= 1'b0;
      end else begin
         wr_err_q <= bus.wr_en && !wr_accept;
         rd_err_q <= 1'b0;

         if (wr_accept) begin
            slots_q[bus.wr_slot]     <= bus.wr_data;
            slot_full_q[bus.wr_slot] <= 1'b1;
         end

         // Read-side updates come after the write so scrubbing always wins.
         unique case (state_q)
            StIdle: begin
               if (bus.rd_req) begin
                  if (slot_full_q[bus.rd_slot]) begin
                     rd_slot_q <= bus.rd_slot;
                     state_q   <= StFetch;
                  end else begin
                     rd_err_q <= 1'b1;
                  end
               end
            end
            StFetch: begin
               out_data_q  <= slots_q[rd_slot_q];
               out_valid_q <= 1'b1;
               state_q     <= StPresent;
            end
            StPresent: begin
               if (bus.out_ready) begin
                  out_data_q             <= '0;
                  out_valid_q            <= 1'b0;
                  slots_q[rd_slot_q]     <= '0;
                  slot_full_q[rd_slot_q] <= 1'b0;
                  state_q                <= StScrub;
               end
            end
            StScrub: begin
               slots_q[rd_slot_q]     <= '0;
               slot_full_q[rd_slot_q] <= 1'b0;
               state_q                <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign bus.wr_err    = wr_err_q;
   assign bus.rd_err    = rd_err_q;
   assign bus.rd_busy   = (state_q != StIdle);
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.slot_full = slot_full_q;
endmodule
